// File: rtl/iq_integrator_lanes_if.sv
// Sample/control bundle and result handshake for the multi-lane I/Q integrator.
// The slave side is the integrator. The master side feeds samples and consumes results.
interface iq_integrator_lanes_if #(
  parameter int LANES = 5,
  parameter int DW    = 16,
  parameter int ACC_W = 32,
  parameter int LEN_W = 11
);
  logic                    start;
  logic                    abort;
  logic [LEN_W-1:0]        sample_length;
  logic [LANES-1:0]        lane_valid;
  logic [LANES*DW-1:0]     data_i_rot;
  logic [LANES*DW-1:0]     data_q_rot;
  logic                    iq_ready;
  logic                    iq_valid;
  logic [ACC_W-1:0]        i_val;
  logic [ACC_W-1:0]        q_val;
  logic                    overflow;
  logic                    overrun;
  logic                    busy;

  modport master (
    output start, abort, sample_length, lane_valid, data_i_rot, data_q_rot, iq_ready,
    input  iq_valid, i_val, q_val, overflow, overrun, busy
  );

  modport slave (
    input  start, abort, sample_length, lane_valid, data_i_rot, data_q_rot, iq_ready,
    output iq_valid, i_val, q_val, overflow, overrun, busy
  );
endinterface

// File: rtl/iq_integrator_lanes.sv
// Multi-lane saturating I/Q integrator: sums LANES masked samples per beat over a
// programmable run length and hands the result over a held valid/ready register.
module iq_integrator_lanes #(
  parameter int LANES = 5,
  parameter int DW    = 16,
  parameter int ACC_W = 32,
  parameter int LEN_W = 11
) (
  input  logic                 clk100,
  input  logic                 reset,
  iq_integrator_lanes_if.slave bus
);

  localparam int SW = DW + $clog2(LANES);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_INTEGRATE = 1'b1
  } state_t;

  function automatic logic signed [SW-1:0] beat_sum(
    input logic [LANES-1:0]    mask,
    input logic [LANES*DW-1:0] data
  );
    logic signed [SW-1:0] sum;
    sum = '0;
    for (int k = 0; k < LANES; k++) begin
      if (mask[k]) begin
        sum = sum + SW'($signed(data[k*DW +: DW]));
      end else begin
        sum = sum;
      end
    end
    return sum;
  endfunction

  // MSB of the return value flags that the sum had to be clamped.
  function automatic logic [ACC_W:0] sat_add(
    input logic signed [ACC_W-1:0] acc,
    input logic signed [SW-1:0]    inc
  );
    logic signed [ACC_W:0] full;
    full = (ACC_W+1)'(acc) + (ACC_W+1)'(inc);
    if (full[ACC_W] != full[ACC_W-1]) begin
      return {1'b1, (full[ACC_W] ? ACC_MIN : ACC_MAX)};
    end else begin
      return {1'b0, full[ACC_W-1:0]};
    end
  endfunction

  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
  logic signed [ACC_W-1:0] acc_q_q, acc_q_d;
  logic                    sat_q, sat_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;
  logic [ACC_W-1:0]        ival_q, ival_d;
  logic [ACC_W-1:0]        qval_q, qval_d;
  logic                    ovf_q, ovf_d;
  logic                    overrun_q, overrun_d;
  logic                    done_s;
  logic signed [SW-1:0]    bs_i_s, bs_q_s;
  logic [ACC_W:0]          sum_i_s, sum_q_s;

  assign bs_i_s  = beat_sum(bus.lane_valid, bus.data_i_rot);
  assign bs_q_s  = beat_sum(bus.lane_valid, bus.data_q_rot);
  assign sum_i_s = sat_add(acc_i_q, bs_i_s);
  assign sum_q_s = sat_add(acc_q_q, bs_q_s);

  // Run control: start/abort decisions, per-beat accumulation and completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    sat_d   = sat_q;
    done_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort && (bus.sample_length != '0)) begin
          state_d = ST_INTEGRATE;
          cnt_d   = '0;
          len_d   = bus.sample_length;
          acc_i_d = '0;
          acc_q_d = '0;
          sat_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INTEGRATE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          acc_i_d = sum_i_s[ACC_W-1:0];
          acc_q_d = sum_q_s[ACC_W-1:0];
          sat_d   = sat_q | sum_i_s[ACC_W] | sum_q_s[ACC_W];
          cnt_d   = cnt_q + LEN_W'(1);
          if (cnt_q == (len_q - LEN_W'(1))) begin
            done_s  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_INTEGRATE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output register: load on completion when free or being drained, else drop and flag overrun.
  always_comb begin
    valid_d   = valid_q;
    ival_d    = ival_q;
    qval_d    = qval_q;
    ovf_d     = ovf_q;
    overrun_d = overrun_q;
    busy_d    = (state_d == ST_INTEGRATE);
    if (done_s) begin
      if (!valid_q || bus.iq_ready) begin
        valid_d = 1'b1;
        ival_d  = acc_i_d;
        qval_d  = acc_q_d;
        ovf_d   = sat_d;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && bus.iq_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk100) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      acc_i_q   <= '0;
      acc_q_q   <= '0;
      sat_q     <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      ival_q    <= '0;
      qval_q    <= '0;
      ovf_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      acc_i_q   <= acc_i_d;
      acc_q_q   <= acc_q_d;
      sat_q     <= sat_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      ival_q    <= ival_d;
      qval_q    <= qval_d;
      ovf_q     <= ovf_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.iq_valid = valid_q;
  assign bus.i_val    = ival_q;
  assign bus.q_val    = qval_q;
  assign bus.overflow = ovf_q;
  assign bus.overrun  = overrun_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_iq_integrator_lanes.sv
// Bench for iq_integrator_lanes: a 32-bit and a 20-bit accumulator instance share one
// stimulus stream and are compared every cycle against an integer reference model.
module tb_iq_integrator_lanes;
  localparam int LANES = 5;
  localparam int DW    = 16;
  localparam int LEN_W = 11;

  logic clk100 = 1'b0;
  logic reset;
  always #5 clk100 = ~clk100;

  iq_integrator_lanes_if #(.LANES(LANES), .DW(DW), .ACC_W(32), .LEN_W(LEN_W)) bus32 ();
  iq_integrator_lanes_if #(.LANES(LANES), .DW(DW), .ACC_W(20), .LEN_W(LEN_W)) bus20 ();

  assign bus20.start         = bus32.start;
  assign bus20.abort         = bus32.abort;
  assign bus20.sample_length = bus32.sample_length;
  assign bus20.lane_valid    = bus32.lane_valid;
  assign bus20.data_i_rot    = bus32.data_i_rot;
  assign bus20.data_q_rot    = bus32.data_q_rot;
  assign bus20.iq_ready      = bus32.iq_ready;

  iq_integrator_lanes #(.LANES(LANES), .DW(DW), .ACC_W(32), .LEN_W(LEN_W)) u_dut32 (
    .clk100 (clk100),
    .reset  (reset),
    .bus    (bus32)
  );

  iq_integrator_lanes #(.LANES(LANES), .DW(DW), .ACC_W(20), .LEN_W(LEN_W)) u_dut20 (
    .clk100 (clk100),
    .reset  (reset),
    .bus    (bus20)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic                    r_reset, r_start, r_abort, r_ready;
  logic [LEN_W-1:0]        r_len;
  logic [LANES-1:0]        r_mask;
  logic signed [DW-1:0]    r_di [LANES];
  logic signed [DW-1:0]    r_dq [LANES];

  bit     m_run, m_valid, m_overrun;
  int     m_left;
  longint m_ai [2];
  longint m_aq [2];
  bit     m_sat [2];
  longint m_i [2];
  longint m_q [2];
  bit     m_ovf [2];

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int acc_width(input int w);
    return (w == 0) ? 32 : 20;
  endfunction

  function automatic longint clampw(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (acc_width(w) - 1)) - 1;
    lo = -(longint'(1) <<< (acc_width(w) - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_update();
    longint bi, bq;
    bit done;
    if (r_reset) begin
      m_run = 0; m_left = 0; m_valid = 0; m_overrun = 0;
      for (int w = 0; w < 2; w++) begin
        m_ai[w] = 0; m_aq[w] = 0; m_sat[w] = 0;
        m_i[w] = 0; m_q[w] = 0; m_ovf[w] = 0;
      end
    end else begin
      done = 0; bi = 0; bq = 0;
      for (int k = 0; k < LANES; k++) begin
        if (r_mask[k]) begin
          bi += longint'(r_di[k]);
          bq += longint'(r_dq[k]);
        end
      end
      if (!m_run) begin
        if (r_start && !r_abort && r_len != 0) begin
          m_run = 1;
          m_left = int'(r_len);
          for (int w = 0; w < 2; w++) begin
            m_ai[w] = 0; m_aq[w] = 0; m_sat[w] = 0;
          end
        end
      end else if (r_abort) begin
        m_run = 0;
      end else begin
        for (int w = 0; w < 2; w++) begin
          longint ni, nq;
          ni = m_ai[w] + bi;
          nq = m_aq[w] + bq;
          if (clampw(ni, w) != ni || clampw(nq, w) != nq) m_sat[w] = 1;
          m_ai[w] = clampw(ni, w);
          m_aq[w] = clampw(nq, w);
        end
        m_left--;
        if (m_left == 0) begin
          done = 1;
          m_run = 0;
        end
      end
      if (done) begin
        if (!m_valid || r_ready) begin
          m_valid = 1;
          for (int w = 0; w < 2; w++) begin
            m_i[w] = m_ai[w]; m_q[w] = m_aq[w]; m_ovf[w] = m_sat[w];
          end
        end else begin
          m_overrun = 1;
        end
      end else if (m_valid && r_ready) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic compare();
    check_val("valid32",   longint'(bus32.iq_valid), longint'(m_valid));
    check_val("busy32",    longint'(bus32.busy),     longint'(m_run));
    check_val("overrun32", longint'(bus32.overrun),  longint'(m_overrun));
    check_val("ovf32",     longint'(bus32.overflow), longint'(m_ovf[0]));
    check_val("ival32",    longint'($signed(bus32.i_val)), m_i[0]);
    check_val("qval32",    longint'($signed(bus32.q_val)), m_q[0]);
    check_val("valid20",   longint'(bus20.iq_valid), longint'(m_valid));
    check_val("busy20",    longint'(bus20.busy),     longint'(m_run));
    check_val("overrun20", longint'(bus20.overrun),  longint'(m_overrun));
    check_val("ovf20",     longint'(bus20.overflow), longint'(m_ovf[1]));
    check_val("ival20",    longint'($signed(bus20.i_val)), m_i[1]);
    check_val("qval20",    longint'($signed(bus20.q_val)), m_q[1]);
  endtask

  task automatic step();
    logic [LANES*DW-1:0] pi, pq;
    for (int k = 0; k < LANES; k++) begin
      pi[k*DW +: DW] = r_di[k];
      pq[k*DW +: DW] = r_dq[k];
    end
    reset               = r_reset;
    bus32.start         = r_start;
    bus32.abort         = r_abort;
    bus32.sample_length = r_len;
    bus32.lane_valid    = r_mask;
    bus32.data_i_rot    = pi;
    bus32.data_q_rot    = pq;
    bus32.iq_ready      = r_ready;
    model_update();
    @(posedge clk100);
    #1;
    compare();
  endtask

  task automatic set_all(input int iv, input int qv);
    for (int k = 0; k < LANES; k++) begin
      r_di[k] = DW'(iv);
      r_dq[k] = DW'(qv);
    end
  endtask

  task automatic run_start(input int n);
    r_len = LEN_W'(n);
    r_start = 1'b1;
    step();
    r_start = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  initial begin
    r_reset = 1'b1; r_start = 1'b0; r_abort = 1'b0; r_ready = 1'b1;
    r_len = '0; r_mask = 5'b11111;
    set_all(0, 0);
    steps(2);
    check_val("rst_ival", longint'($signed(bus32.i_val)), 0);
    r_reset = 1'b0;
    step();

    // basic run, all lanes
    set_all(100, -50);
    run_start(4);
    steps(4);
    check_val("t1_valid", longint'(bus32.iq_valid), 1);
    check_val("t1_ival", longint'($signed(bus32.i_val)), 2000);
    check_val("t1_qval", longint'($signed(bus32.q_val)), -1000);
    check_val("t1_ovf", longint'(bus32.overflow), 0);
    step();
    check_val("t1_drop", longint'(bus32.iq_valid), 0);

    // lane mask, length changed mid-run
    r_mask = 5'b00101;
    for (int k = 0; k < LANES; k++) begin
      r_di[k] = DW'(k + 1);
      r_dq[k] = DW'(-(k + 1));
    end
    run_start(3);
    r_len = LEN_W'(7);
    steps(3);
    check_val("t2_valid", longint'(bus32.iq_valid), 1);
    check_val("t2_ival", longint'($signed(bus32.i_val)), 12);
    check_val("t2_qval", longint'($signed(bus32.q_val)), -12);
    step();

    // saturation on the 20-bit instance, then a clean run
    r_mask = 5'b11111;
    set_all(32767, -32768);
    run_start(8);
    steps(8);
    check_val("t3_ival20", longint'($signed(bus20.i_val)), 524287);
    check_val("t3_qval20", longint'($signed(bus20.q_val)), -524288);
    check_val("t3_ovf20", longint'(bus20.overflow), 1);
    check_val("t3_ival32", longint'($signed(bus32.i_val)), 1310680);
    step();
    set_all(1, -32768);
    run_start(1);
    step();
    check_val("t3b_ival20", longint'($signed(bus20.i_val)), 5);
    check_val("t3b_ovf20", longint'(bus20.overflow), 0);
    step();

    // overrun while the consumer stalls
    r_ready = 1'b0;
    set_all(100, -50);
    run_start(4);
    steps(4);
    set_all(10, 0);
    run_start(2);
    steps(2);
    check_val("t4_ival", longint'($signed(bus32.i_val)), 2000);
    check_val("t4_overrun", longint'(bus32.overrun), 1);
    check_val("t4_valid", longint'(bus32.iq_valid), 1);
    r_ready = 1'b1;
    step();
    check_val("t4_drop", longint'(bus32.iq_valid), 0);
    check_val("t4_sticky", longint'(bus32.overrun), 1);

    // abort at beat 2
    run_start(10);
    step();
    r_abort = 1'b1;
    step();
    r_abort = 1'b0;
    check_val("abort_busy", longint'(bus32.busy), 0);
    steps(12);
    check_val("abort_novalid", longint'(bus32.iq_valid), 0);

    // start+abort together, and zero length
    r_abort = 1'b1;
    run_start(4);
    r_abort = 1'b0;
    check_val("sa_busy", longint'(bus32.busy), 0);
    run_start(0);
    check_val("len0_busy", longint'(bus32.busy), 0);
    steps(2);

    // reset mid-run
    run_start(10);
    steps(4);
    r_reset = 1'b1;
    step();
    r_reset = 1'b0;
    check_val("mrst_busy", longint'(bus32.busy), 0);
    check_val("mrst_overrun", longint'(bus32.overrun), 0);
    check_val("mrst_ival", longint'($signed(bus32.i_val)), 0);
    set_all(100, -50);
    run_start(2);
    steps(2);
    check_val("mrst_run_ival", longint'($signed(bus32.i_val)), 1000);
    step();

    // back-to-back: start in completion cycle ignored, next cycle accepted
    r_ready = 1'b0;
    run_start(3);
    steps(2);
    r_start = 1'b1;
    step();
    check_val("b2b_busy", longint'(bus32.busy), 0);
    set_all(7, 3);
    run_start(2);
    step();
    check_val("b2b_first", longint'($signed(bus32.i_val)), 1500);
    r_ready = 1'b1;
    step();
    check_val("b2b_second_i", longint'($signed(bus32.i_val)), 70);
    check_val("b2b_second_q", longint'($signed(bus32.q_val)), 30);
    check_val("b2b_overrun", longint'(bus32.overrun), 0);
    step();

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      r_reset = ($urandom_range(0, 299) == 0);
      r_start = ($urandom_range(0, 7) == 0);
      r_abort = ($urandom_range(0, 39) == 0);
      r_ready = ($urandom_range(0, 1) == 1);
      r_len   = ($urandom_range(0, 15) == 0) ? LEN_W'(0) : LEN_W'($urandom_range(1, 12));
      r_mask  = LANES'($urandom);
      for (int k = 0; k < LANES; k++) begin
        if ($urandom_range(0, 2) == 0) begin
          r_di[k] = ($urandom_range(0, 1) == 1) ? DW'(32767) : DW'(-32768);
          r_dq[k] = ($urandom_range(0, 1) == 1) ? DW'(32767) : DW'(-32768);
        end else begin
          r_di[k] = DW'($urandom);
          r_dq[k] = DW'($urandom);
        end
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/iq_integrator_lanes.md
Name: iq_integrator_lanes

Overview:
- Parametrised successor to the single-shot I/Q integrator in the qubit readout chain. Sits after the demodulation multiplier.
- Each clock it accepts LANES rotated I/Q samples, each gated by a per-lane valid bit. It sums them over a programmable number of beats into saturating accumulators.
- It presents the result through a held valid/ready output register, with abort, overflow and overrun reporting.

Parameters:
LANES, 5, samples per clock beat
DW, 16, signed width of each rotated sample
ACC_W, 32, signed accumulator/result width (must be >= DW + clog2(LANES) + 1)
LEN_W, 11, width of sample_length

Ports:
clk100  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin integration (pulse)
abort  in  1  cancel integration in progress
sample_length  in  LEN_W  number of beats to integrate
lane_valid  in  LANES  per-lane include mask for current beat
data_i_rot  in  LANES*DW  packed signed I samples, lane k at [k*DW +: DW]
data_q_rot  in  LANES*DW  packed signed Q samples, same packing
iq_ready  in  1  consumer accepts result
iq_valid  out  1  result available
i_val  out  ACC_W  signed integrated I
q_val  out  ACC_W  signed integrated Q
overflow  out  1  saturation occurred in the presented result
overrun  out  1  sticky: a completed result was dropped
busy  out  1  high while in INTEGRATE

Behaviour:
- One clock (clk100); reset is synchronous and active-high.
- Reset (including mid-operation):
  - state=IDLE.
  - Accumulators, beat counter, iq_valid, i_val, q_val, overflow, overrun, busy all 0.
- States: IDLE, INTEGRATE.
- IDLE:
  - start=1, abort=0 and sample_length!=0: clear accumulators and the per-run saturation flag, counter=0, go to INTEGRATE, busy=1.
  - start with sample_length=0: ignored.
  - start and abort in the same cycle: abort wins, stay in IDLE.
- INTEGRATE:
  - Every cycle is one beat. First beat is the cycle after start is sampled.
  - Beat sum = sum over k of lane_valid[k] ? sext(data[k]) : 0. Computed at DW+clog2(LANES) bits, then sign-extended.
  - acc_next = acc + beat_sum, computed at ACC_W+1 bits.
  - If acc_next is out of ACC_W signed range: clamp to max/min and set the run saturation flag. Once set, the flag stays set for the run. I and Q are handled independently, with one shared flag.
  - Counter increments each beat. On the beat where counter==sample_length-1, the run completes: state to IDLE, busy=0.
  - start while in INTEGRATE: ignored. sample_length is sampled only at start, so later changes have no effect on the current run.
  - abort=1: immediately go to IDLE, busy=0, no result is produced. abort has priority over completion in the same cycle.
- Latency: start sampled at cycle t, beats at t+1..t+N, iq_valid=1 at t+N+1.
- Output register:
  - On completion: if iq_valid=0, or iq_valid=1 and iq_ready=1 in that cycle, load i_val, q_val and overflow=run flag, and set iq_valid=1.
  - Otherwise keep the old result, drop the new one, and set overrun=1. overrun is cleared only by reset.
  - iq_valid && iq_ready with no completion that cycle: iq_valid=0. i_val, q_val and overflow keep their last values.
  - While iq_valid=1 and iq_ready=0, the outputs are stable.
- A new run may start while an unconsumed result is held in the output register. The accumulators are independent of the output register.
- Arithmetic is two's complement throughout. The beat sum cannot overflow internally.

Test Plan:
- LANES=5, N=4, lane_valid=5'b11111, every I lane=100, every Q lane=-50, iq_ready=1 -> iq_valid pulses 1 cycle at start+5 with i_val=2000, q_val=-1000, overflow=0.
- N=3, lane_valid=5'b00101, I lanes=1,2,3,4,5 (lane0..4), Q lanes=-1..-5 -> i_val=12, q_val=-12. Change sample_length mid-run to 7 -> still completes after 3 beats.
- ACC_W=20, N=8, all lanes I=32767, Q=-32768 -> i_val=524287, q_val=-524288, overflow=1. Next run with I=1, N=1, all lanes -> i_val=5, overflow=0.
- iq_ready=0: run A (result 2000), then run B (N=2, I=10) completes -> i_val stays 2000, overrun=1. iq_ready=1 -> iq_valid drops next cycle, overrun stays 1.
- Edge cases:
  - abort at beat 2 of N=10 -> no iq_valid, busy=0 next cycle.
  - start+abort in IDLE -> no run.
  - start with sample_length=0 -> no run.
  - reset at beat 5 -> all outputs 0, then a fresh run gives a correct result.
- Back-to-back: start asserted in the completion cycle of the previous run -> that start is ignored (state is still INTEGRATE). start one cycle later -> second result correct, first result (held until ready) also correct.
